apb_mem_slave_ws: RTL
=====================

Name: apb_mem_slave_ws

Overview:
- Parametrised APB4 memory-mapped slave for NoC configuration/status space: word-addressed register file with byte strobes, programmable wait states and PSLVERR reporting.
- Successor to the 8-bit fixed-depth APB memory slave: generalised data/address width and depth; adds strobes, wait-state insertion, error response, protocol tracking and an error counter.
- Sits behind the APB bridge/decoder; one instance per PSEL line.

Parameters:
- DATA_W, 32, data bus width in bits; must be 8, 16, 32 or 64.
- ADDR_W, 12, PADDR width in bits (byte address).
- DEPTH, 256, number of DATA_W-bit words; must be <= 2^(ADDR_W - log2(DATA_W/8)).
- WAIT_CYCLES, 0, number of wait states inserted per transfer (0..15).
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- pclk  input  1  APB clock; all state updates on the rising edge.
- presetn  input  1  asynchronous, active-low reset.
- psel  input  1  slave select.
- penable  input  1  access-phase indicator.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_W  byte address.
- pwdata  input  DATA_W  write data.
- pstrb  input  DATA_W/8  write byte strobes; ignored on reads.
- prdata  output  DATA_W  read data; valid only when pready && !pwrite && !pslverr, otherwise 0.
- pready  output  1  transfer completes this cycle.
- pslverr  output  1  error response; valid only with pready, otherwise 0.
- err_count  output  ERRCNT_W  saturating count of completed error transfers.

Behaviour:
- Reset: state = IDLE, wait counter = 0, err_count = 0, prdata/pready/pslverr = 0. Memory contents are not reset (X until written).
- Reset asserted mid-transfer aborts it: no write commits, and the FSM restarts in IDLE.
- FSM states:
  - IDLE: psel && !penable -> SETUP; psel && penable -> ACCESS and flag a protocol error.
  - SETUP: load counter with WAIT_CYCLES and latch the address; next state is always ACCESS.
  - ACCESS: if counter != 0, decrement and hold pready = 0. If counter == 0, assert pready. Next state is SETUP if psel && !penable, otherwise IDLE.
- Protocol error: psel dropped during ACCESS before completion aborts the transfer, with no write and no pready.
- Latency: pready is asserted in the (WAIT_CYCLES+1)-th ACCESS cycle. With 0 wait states the transfer takes 2 cycles (setup + access).
- pready and pslverr are combinational from state, counter and the latched decode. prdata is a combinational memory read, masked to 0 when not valid.
- Address decode: word index = paddr >> log2(DATA_W/8).
  - Error if the low byte-offset bits are nonzero (misaligned).
  - Error if word index >= DEPTH.
  - Error if the transfer entered ACCESS without a SETUP cycle.
- Write commit: on the pclk edge where pready && pwrite && !pslverr, update only the byte lanes with pstrb[i] = 1. pstrb = 0 is a legal no-op write that completes without error.
- Error transfers: write nothing, return prdata = 0, and increment err_count on the completing edge. err_count saturates at all-ones.
- Address/control sampled in SETUP are held through ACCESS per APB rules. The slave uses the SETUP-latched paddr/pwrite; pwdata/pstrb are sampled at completion.
- Back-to-back transfers: SETUP may follow the completing ACCESS cycle directly; no idle cycle is required.
- Read-after-write to the same word in consecutive transfers returns the new data.

Decomposition:
- Shared package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS};
  - response constants RESP_OKAY = 0, RESP_SLVERR = 1;
  - function clog2 helper;
  - function for the strobe-mask expansion (pstrb to per-bit mask).
- Sub-module apb_ws_ctrl: FSM, wait counter, protocol-error detection; outputs pready and an access-complete pulse.
- Top level holds the decode, memory array, strobe merge and err_count.

Test Plan:
- Reset with psel = 1, penable = 1 held -> pready = 0, pslverr = 0, prdata = 0, err_count = 0 throughout reset.
- WAIT_CYCLES = 0, DATA_W = 32: write 0xDEADBEEF to 0x010 with pstrb = 0xF, then read 0x010 -> pready in the 2nd cycle of each transfer; read returns 0xDEADBEEF, pslverr = 0.
- Byte strobes: write 0x11223344 with pstrb = 0b0101 over an existing 0xDEADBEEF -> read returns 0xDE22BE44.
- WAIT_CYCLES = 3: single read -> pready low for 3 ACCESS cycles and high in the 4th; prdata stays 0 until then.
- Errors with DEPTH = 256: read of 0x400 (out of range), then write to 0x013 (misaligned) -> each completes with pready = pslverr = 1, memory unchanged, err_count = 2.
- Protocol/saturation: psel && penable without a SETUP cycle -> pslverr = 1. Force 300 error transfers with ERRCNT_W = 8 -> err_count holds at 255.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB memory slave: bus phase encoding,
// response codes, and the byte-strobe to bit-mask expansion.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  // Sized for the widest legal bus (64 bits); callers truncate to their width.
  function automatic logic [63:0] strb_mask(input logic [7:0] strb);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      m[i*8 +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/apb_ws_ctrl.sv
// Transfer sequencer for the APB memory slave: bus phase tracking, wait-state
// counter and detection of access phases that had no preceding setup phase.
module apb_ws_ctrl
  import apb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic pclk,
  input  logic presetn,
  input  logic psel,
  input  logic penable,
  output logic pready,
  output logic complete,
  output logic setup_en,
  output logic proto_err
);

  state_t     state_q;
  state_t     state_d;
  state_t     cur_st;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The register only remembers an in-flight access; outside one, the phase of
  // the current cycle is read off the bus so setup and access are adjacent cycles.
  always_comb begin
    cur_st    = IDLE;
    state_d   = IDLE;
    cnt_d     = cnt_q;
    pready    = 1'b0;
    complete  = 1'b0;
    setup_en  = 1'b0;
    proto_err = 1'b0;

    if (presetn) begin
      if (state_q == ACCESS) begin
        cur_st = ACCESS;
      end else if (psel) begin
        cur_st = penable ? ACCESS : SETUP;
      end
    end

    unique case (cur_st)
      SETUP: begin
        setup_en = 1'b1;
        state_d  = ACCESS;
        cnt_d    = 4'(WAIT_CYCLES);
      end
      ACCESS: begin
        // Counter is always zero outside a transfer, so an unannounced access
        // completes immediately with an error.
        proto_err = (state_q != ACCESS);
        if (!psel) begin
          cnt_d = '0;
        end else if (cnt_q != '0) begin
          cnt_d   = cnt_q - 1'b1;
          state_d = ACCESS;
        end else begin
          pready   = 1'b1;
          complete = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/apb_mem_slave_ws.sv
// APB4 word-addressed register file with byte strobes, programmable wait states,
// PSLVERR on misaligned/out-of-range/unannounced accesses, and an error counter.
module apb_mem_slave_ws
  import apb_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ERRCNT_W    = 8
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [ERRCNT_W-1:0]   err_count
);

  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned OFFS = clog2(NB);
  localparam int unsigned IW   = (DEPTH > 1) ? clog2(DEPTH) : 1;

  if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("apb_mem_slave_ws: DATA_W must be 8, 16, 32 or 64");
  end
  if (64'(DEPTH) > (64'd1 << (ADDR_W - OFFS))) begin : g_bad_depth
    $error("apb_mem_slave_ws: DEPTH exceeds the addressable word range");
  end
  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("apb_mem_slave_ws: WAIT_CYCLES must be 0..15");
  end

  logic              pready_c;
  logic              complete;
  logic              setup_en;
  logic              proto_err;
  logic [ADDR_W-1:0] widx;
  logic              misaligned;
  logic              out_of_range;
  logic [IW-1:0]     idx_q;
  logic              dec_err_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] wmask;
  logic [DATA_W-1:0] rword;
  logic              slverr;
  logic              we;
  logic [DATA_W-1:0] mem [DEPTH];

  apb_ws_ctrl #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_ctrl (
    .pclk     (pclk),
    .presetn  (presetn),
    .psel     (psel),
    .penable  (penable),
    .pready   (pready_c),
    .complete (complete),
    .setup_en (setup_en),
    .proto_err(proto_err)
  );

  always_comb begin
    widx         = paddr >> OFFS;
    misaligned   = (paddr & ADDR_W'(NB - 1)) != '0;
    out_of_range = 64'(widx) >= 64'(DEPTH);
  end

  // Decode is frozen at setup; pwdata/pstrb are taken live at completion.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      idx_q     <= '0;
      dec_err_q <= 1'b0;
      pwrite_q  <= 1'b0;
    end else if (setup_en) begin
      idx_q     <= widx[IW-1:0];
      dec_err_q <= misaligned || out_of_range;
      pwrite_q  <= pwrite;
    end
  end

  always_comb begin
    slverr  = (pready_c && (proto_err || dec_err_q)) ? RESP_SLVERR : RESP_OKAY;
    we      = complete && pwrite_q && !slverr;
    wmask   = DATA_W'(strb_mask(8'(pstrb)));
    rword   = mem[idx_q];
    prdata  = (pready_c && !pwrite_q && !slverr) ? rword : '0;
    pready  = pready_c;
    pslverr = slverr;
  end

  always_ff @(posedge pclk) begin
    if (we) begin
      mem[idx_q] <= (mem[idx_q] & ~wmask) | (pwdata & wmask);
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      err_count <= '0;
    end else if (complete && slverr && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule
